pll_reset_sequencer: RTL and testbench
======================================

# pll_reset_sequencer

Controller on the far side of the PLL interface: drives the PLL's reset input, consumes its asynchronous `locked` output, and turns lock status into a clean system reset for the rest of the design. Runs on the board reference clock, never on a PLL output. Re-pulses the PLL reset if lock is not achieved within a timeout. Holds the system in reset until lock has been continuously stable for a programmable time. Reasserts system reset whenever lock is lost.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flops in the `pll_locked` synchronizer; must be ≥2.
- `PLL_RST_CYCLES`, 16: length of each `pll_rst` pulse, in `refclk` cycles; must be ≥1.
- `LOCK_TIMEOUT`, 50000: cycles to wait for lock before re-pulsing `pll_rst` (1 ms at 50 MHz); must be ≥1.
- `STABLE_CYCLES`, 1000: cycles lock must stay high before release (20 µs at 50 MHz); must be ≥1.
- `CNT_W`, 16: shared cycle-counter width; every cycle parameter must be < 2^CNT_W.

Ports:
- `refclk` in 1: reference clock (50 MHz); the only clock.
- `rst` in 1: reset, asynchronous, active-high.
- `pll_locked` in 1: PLL lock indication, asynchronous to `refclk`.
- `pll_rst` out 1: reset request to the PLL, active-high.
- `sys_rst` out 1: system reset, active-high, synchronous to `refclk`.
- `ready` out 1: high exactly when `sys_rst` is low.
- `fail_count` out 4: count of lock timeouts, saturating at 15.
- `relock_count` out 8: count of lock losses while in RUN, saturating at 255.

## Operation
- The synchronizer is a chain of `SYNC_STAGES` flops, all reset to 0. Its last stage is `locked_s`.
- One counter `cnt` of width `CNT_W` is shared by all states. It is cleared on every state transition and increments on each cycle spent in a state.
- States: PLL_RESET, WAIT_LOCK, STABLE, RUN.
- PLL_RESET
  - If `cnt==PLL_RST_CYCLES-1`, go to WAIT_LOCK.
  - Otherwise `cnt++`.
- WAIT_LOCK
  - If `locked_s`, go to STABLE.
  - Else if `cnt==LOCK_TIMEOUT-1`, go to PLL_RESET and increment `fail_count` (saturating).
  - Otherwise `cnt++`.
- STABLE
  - If `!locked_s`, go to WAIT_LOCK. No counter increments.
  - Else if `cnt==STABLE_CYCLES-1`, go to RUN.
  - Otherwise `cnt++`.
- RUN
  - If `!locked_s`, go to WAIT_LOCK and increment `relock_count` (saturating).
  - The PLL is not reset on lock loss.
- Outputs are registered and decoded from the next state, so they change on the same edge as the state register:
  - `pll_rst` = (state==PLL_RESET).
  - `sys_rst` = (state!=RUN).
  - `ready` = (state==RUN).
- Simultaneous events:
  - In WAIT_LOCK, lock beats timeout on the same cycle.
  - In STABLE, loss beats completion on the final count.
- Counters never wrap: `fail_count` holds at 15, `relock_count` holds at 255.

## Timing
- Asserting `rst` immediately (asynchronously) forces, with no clock edge required:
  - state PLL_RESET, `cnt`=0, synchronizer=0;
  - `pll_rst`=1, `sys_rst`=1, `ready`=0;
  - `fail_count`=0, `relock_count`=0.
- The same applies to reset asserted mid-operation, including in RUN.
- After `rst` falls, `pll_rst` stays high for exactly `PLL_RST_CYCLES` rising edges. It falls on edge `PLL_RST_CYCLES`.
- Lock acquisition: `pll_locked` rises before edge k and stays high.
  - STABLE is entered at edge k+`SYNC_STAGES`.
  - `sys_rst` falls and `ready` rises at edge k+`SYNC_STAGES`+`STABLE_CYCLES`.
- Lock loss in RUN: `pll_locked` falls before edge m.
  - `sys_rst` rises at edge m+`SYNC_STAGES`.
  - `relock_count` updates on the same edge.
- Timeout: WAIT_LOCK is entered at edge w with `locked_s` low throughout.
  - `pll_rst` rises and `fail_count` increments at edge w+`LOCK_TIMEOUT`.
- `sys_rst` never toggles within a cycle. It has no combinational path from `pll_locked`.

## Test plan
Parameters for all scenarios: `SYNC_STAGES`=2, `PLL_RST_CYCLES`=3, `LOCK_TIMEOUT`=20, `STABLE_CYCLES`=4.

- Power-up pulse: release `rst` with `pll_locked`=0 → `pll_rst`=1 through edges 1–2 and falls at edge 3; `sys_rst`=1 throughout.
- Normal lock: raise `pll_locked` before edge 10 → `sys_rst` falls and `ready` rises at edge 16; `fail_count`=0.
- Timeout: hold `pll_locked`=0 → `pll_rst` re-rises at edge 23 for 3 cycles and `fail_count`=1. After 16 further timeouts, `fail_count` stays at 15.
- Glitch in STABLE: raise lock before edge 10, drop it before edge 13, raise it before edge 15 → `sys_rst` stays 1 until edge 21; `relock_count`=0.
- Loss in RUN: after `ready`=1, drop `pll_locked` before edge m → `sys_rst`=1 at m+2, `relock_count`=1, `pll_rst` stays 0. Relock completes 6 edges after lock returns.
- Async reset in RUN: assert `rst` between edges → `sys_rst`=1, `pll_rst`=1, and both counts read 0 before the next edge.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// Turns PLL lock status into a clean refclk-domain system reset.
// The PLL reset is re-pulsed on lock timeout; lock must be stable before the system is released.
module pll_reset_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 50000,
  parameter int STABLE_CYCLES  = 1000,
  parameter int CNT_W          = 16
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic [3:0] fail_count,
  output logic [7:0] relock_count
);

  typedef enum logic [1:0] {PLL_RESET, WAIT_LOCK, STABLE, RUN} state_t;

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ST_LAST  = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;
  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic                   fail_inc, relock_inc;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
  end

  assign locked_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt + 1'b1;
    fail_inc   = 1'b0;
    relock_inc = 1'b0;
    case (state)
      PLL_RESET: if (cnt == RST_LAST) state_nxt = WAIT_LOCK;
      WAIT_LOCK: begin
        // lock wins over a timeout landing on the same cycle
        if (locked_s) state_nxt = STABLE;
        else if (cnt == TO_LAST) begin
          state_nxt = PLL_RESET;
          fail_inc  = 1'b1;
        end
      end
      STABLE: begin
        if (!locked_s)           state_nxt = WAIT_LOCK;
        else if (cnt == ST_LAST) state_nxt = RUN;
      end
      RUN: begin
        if (!locked_s) begin
          state_nxt  = WAIT_LOCK;
          relock_inc = 1'b1;
        end
      end
      default: state_nxt = PLL_RESET;
    endcase
    // RUN has no timing role, so its counter is parked at zero
    if (state_nxt != state || state == RUN) cnt_nxt = '0;
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state        <= PLL_RESET;
      cnt          <= '0;
      pll_rst      <= 1'b1;
      sys_rst      <= 1'b1;
      ready        <= 1'b0;
      fail_count   <= '0;
      relock_count <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pll_rst <= (state_nxt == PLL_RESET);
      sys_rst <= (state_nxt != RUN);
      ready   <= (state_nxt == RUN);
      if (fail_inc && fail_count != 4'hF)     fail_count   <= fail_count + 1'b1;
      if (relock_inc && relock_count != 8'hFF) relock_count <= relock_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench: expectations are queued against edge numbers counted from reset release
// and checked on the falling edge after that rising edge.
module tb_pll_reset_sequencer;
  localparam int SS = 2, PRC = 3, LT = 20, SC = 4;
  localparam int S_PRST = 0, S_SRST = 1, S_RDY = 2, S_FAIL = 3, S_RELOCK = 4;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       pll_rst, sys_rst, ready;
  logic [3:0] fail_count;
  logic [7:0] relock_count;

  pll_reset_sequencer #(
    .SYNC_STAGES(SS), .PLL_RST_CYCLES(PRC), .LOCK_TIMEOUT(LT), .STABLE_CYCLES(SC), .CNT_W(16)
  ) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked),
    .pll_rst(pll_rst), .sys_rst(sys_rst), .ready(ready),
    .fail_count(fail_count), .relock_count(relock_count)
  );

  always #5 refclk = ~refclk;

  typedef struct {
    int    at;
    int    sig;
    int    val;
    string tag;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   total = 0, bad = 0;
  int   cyc = 0, base = 0;
  bit   live = 1'b0;

  always @(posedge refclk) cyc <= cyc + 1;

  function automatic int rel();
    return cyc - base;
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (edge %0d)", tag, got, exp, rel());
    end
  endtask

  function automatic logic [15:0] probe(input int sig);
    case (sig)
      S_PRST:   return 16'(pll_rst);
      S_SRST:   return 16'(sys_rst);
      S_RDY:    return 16'(ready);
      S_FAIL:   return 16'(fail_count);
      default:  return 16'(relock_count);
    endcase
  endfunction

  task automatic expect_at(input int at, input int sig, input int val, input string tag);
    exp_t e;
    int   i;
    e.at = at; e.sig = sig; e.val = val; e.tag = tag;
    i = sb.size();
    while (i > 0 && sb[i-1].at > at) i--;
    sb.insert(i, e);
  endtask

  always @(negedge refclk) begin
    if (live) begin
      while (sb.size() > 0 && sb[0].at <= rel()) begin
        cur = sb.pop_front();
        if (cur.at < rel()) chk({cur.tag, "_missed"}, 16'(rel()), 16'(cur.at));
        else                chk(cur.tag, probe(cur.sig), 16'(cur.val));
      end
    end
  end

  // returns on the falling edge that follows rising edge k
  task automatic till(input int k);
    repeat (5000) begin
      if (rel() >= k) break;
      @(negedge refclk);
    end
    if (rel() < k) chk("till_timeout", 16'(rel()), 16'(k));
  endtask

  task automatic drain();
    repeat (5000) begin
      if (sb.size() == 0) break;
      @(negedge refclk);
    end
    if (sb.size() != 0) chk("drain_timeout", 16'(sb.size()), 16'd0);
  endtask

  task automatic do_reset(input bit check);
    @(negedge refclk);
    live = 1'b0;
    sb.delete();
    rst = 1'b1;
    pll_locked = 1'b0;
    @(negedge refclk);
    if (check) begin
      chk("rst_pll_rst", 16'(pll_rst), 16'd1);
      chk("rst_sys_rst", 16'(sys_rst), 16'd1);
      chk("rst_ready", 16'(ready), 16'd0);
      chk("rst_fail", 16'(fail_count), 16'd0);
      chk("rst_relock", 16'(relock_count), 16'd0);
    end
    @(negedge refclk);
    rst = 1'b0;
    base = cyc;
    live = 1'b1;
  endtask

  // asserts rst mid-cycle and checks the outputs before any further clock edge
  task automatic async_reset_check(input string tag);
    live = 1'b0;
    @(posedge refclk);
    #2 rst = 1'b1;
    #1;
    chk({tag, "_sys_rst"}, 16'(sys_rst), 16'd1);
    chk({tag, "_pll_rst"}, 16'(pll_rst), 16'd1);
    chk({tag, "_ready"}, 16'(ready), 16'd0);
    chk({tag, "_fail"}, 16'(fail_count), 16'd0);
    chk({tag, "_relock"}, 16'(relock_count), 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at edge %0d", rel());
    $fatal(1, "watchdog");
  end

  initial begin
    // power-up pulse, repeated timeouts, fail_count saturation
    do_reset(1'b1);
    for (int e = 1; e <= 2; e++) expect_at(e, S_PRST, 1, "pwr_pll_rst_hi");
    expect_at(3, S_PRST, 0, "pwr_pll_rst_fall");
    for (int e = 1; e <= 3; e++) expect_at(e, S_SRST, 1, "pwr_sys_rst");
    expect_at(22, S_FAIL, 0, "to_fail_pre");
    expect_at(23, S_PRST, 1, "to_pll_rst_rise");
    expect_at(23, S_SRST, 1, "to_sys_rst");
    expect_at(25, S_PRST, 1, "to_pll_rst_hold");
    expect_at(26, S_PRST, 0, "to_pll_rst_fall");
    for (int n = 1; n <= 17; n++) begin
      expect_at(23*n - 1, S_FAIL, (n - 1 > 15) ? 15 : n - 1, $sformatf("to_fail_pre%0d", n));
      expect_at(23*n, S_FAIL, (n > 15) ? 15 : n, $sformatf("to_fail%0d", n));
    end
    drain();

    // normal lock, loss in RUN, relock, relock_count saturation, async reset in RUN
    do_reset(1'b0);
    expect_at(15, S_SRST, 1, "lock_sys_rst_pre");
    expect_at(15, S_RDY, 0, "lock_ready_pre");
    expect_at(16, S_SRST, 0, "lock_sys_rst_fall");
    expect_at(16, S_RDY, 1, "lock_ready_rise");
    expect_at(16, S_FAIL, 0, "lock_fail");
    expect_at(16, S_PRST, 0, "lock_pll_rst");
    till(9);  pll_locked = 1'b1;
    expect_at(21, S_SRST, 0, "loss_sys_rst_pre");
    expect_at(21, S_RELOCK, 0, "loss_relock_pre");
    expect_at(22, S_SRST, 1, "loss_sys_rst");
    expect_at(22, S_RDY, 0, "loss_ready");
    expect_at(22, S_RELOCK, 1, "loss_relock");
    expect_at(22, S_PRST, 0, "loss_pll_rst");
    expect_at(28, S_PRST, 0, "loss_pll_rst_late");
    expect_at(31, S_SRST, 1, "relock_sys_rst_pre");
    expect_at(32, S_SRST, 0, "relock_sys_rst_fall");
    expect_at(32, S_RDY, 1, "relock_ready");
    expect_at(32, S_RELOCK, 1, "relock_count_hold");
    till(19); pll_locked = 1'b0;
    till(25); pll_locked = 1'b1;
    for (int i = 2; i <= 256; i++) begin
      int b;
      b = 30 + 10*i;
      expect_at(b + 1, S_RELOCK, (i - 1 > 255) ? 255 : i - 1, $sformatf("sat_pre%0d", i));
      expect_at(b + 2, S_RELOCK, (i > 255) ? 255 : i, $sformatf("sat%0d", i));
      expect_at(b + 2, S_RDY, 0, $sformatf("sat_rdy_lo%0d", i));
      expect_at(b + 9, S_RDY, 1, $sformatf("sat_rdy_hi%0d", i));
      till(b - 1); pll_locked = 1'b0;
      till(b + 2); pll_locked = 1'b1;
    end
    drain();
    async_reset_check("arst_run");

    // glitch during STABLE restarts the stability window
    do_reset(1'b0);
    expect_at(16, S_SRST, 1, "glitch_sys_rst16");
    expect_at(20, S_SRST, 1, "glitch_sys_rst20");
    expect_at(21, S_SRST, 0, "glitch_sys_rst_fall");
    expect_at(21, S_RDY, 1, "glitch_ready");
    expect_at(21, S_RELOCK, 0, "glitch_relock");
    till(9);  pll_locked = 1'b1;
    till(12); pll_locked = 1'b0;
    till(14); pll_locked = 1'b1;
    drain();

    // lock seen on the timeout cycle wins
    do_reset(1'b0);
    expect_at(23, S_PRST, 0, "tie_pll_rst");
    expect_at(23, S_FAIL, 0, "tie_fail");
    expect_at(26, S_SRST, 1, "tie_sys_rst_pre");
    expect_at(27, S_SRST, 0, "tie_sys_rst_fall");
    expect_at(27, S_RDY, 1, "tie_ready");
    till(20); pll_locked = 1'b1;
    drain();

    // loss on the final STABLE count wins over completion
    do_reset(1'b0);
    expect_at(16, S_SRST, 1, "sloss_sys_rst");
    expect_at(16, S_RDY, 0, "sloss_ready");
    expect_at(20, S_SRST, 1, "sloss_sys_rst20");
    expect_at(20, S_RELOCK, 0, "sloss_relock");
    till(9);  pll_locked = 1'b1;
    till(13); pll_locked = 1'b0;
    drain();

    // one timeout then lock, then async reset clears fail_count
    do_reset(1'b0);
    expect_at(23, S_FAIL, 1, "tl_fail");
    expect_at(35, S_RDY, 0, "tl_ready_pre");
    expect_at(36, S_RDY, 1, "tl_ready");
    expect_at(36, S_FAIL, 1, "tl_fail_hold");
    till(29); pll_locked = 1'b1;
    drain();
    async_reset_check("arst_fail");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
